mux8_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one 16-bit datapath between 8 requesters.
- Drives the 3-bit select of the 8-way 16-bit mux and grants exactly one requester at a time.
- Has a per-grant hold limit so no requester can starve the others.
- Sits between requester masters and the 8-way mux; the mux output feeds the shared consumer, qualified by bus_valid.

---
 rtl/mux8_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_mux8_bus_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux8_bus_arbiter.sv
// mux8_bus_arbiter: round-robin arbiter for an 8-way, 16-bit shared datapath.
// It produces a registered one-hot grant, the matching mux select, a bus
// qualifier and a per-grant cycle counter. A hold limit bounds how long any
// single requester can keep the bus.
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
// wants the bus. It owns the bus only while gnt[i] is high, and it gives the
// bus up by dropping req[i]; ownership then ends at the next rising edge.
// Every output is registered and changes only on the rising edge of clk,
// except during the asynchronous reset.
module mux8_bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       bus_valid,
    output logic [7:0] hold_cnt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     state, state_nxt;
    logic [2:0] last, last_nxt;
    logic [7:0] gnt_nxt;
    logic [2:0] sel_nxt;
    logic       valid_nxt;
    logic [7:0] hold_nxt;
    logic [3:0] pick;
    logic       keep;
    logic       take_grant;

    // Round-robin search starting after pointer p. The loop runs from the
    // farthest candidate to the nearest one, so the nearest requester makes
    // the final assignment and wins. The farthest candidate is p itself,
    // which lets a force-released owner re-win when it is the only requester.
    // The result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 8; k >= 1; k--) begin
            idx = p + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // State and output registers; reset clears the outputs and sets the
    // pointer to 7, so the first search after reset starts at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 3'd7;
            gnt       <= 8'h00;
            sel       <= 3'd0;
            bus_valid <= 1'b0;
            hold_cnt  <= 8'h00;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            gnt       <= gnt_nxt;
            sel       <= sel_nxt;
            bus_valid <= valid_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

    // Next-state logic. In GRANT the owner is always sel, which is also equal
    // to last. A grant is kept while the owner still requests and the hold
    // limit has not been reached. Otherwise the bus goes to the next requester
    // with no idle cycle, or the arbiter returns to IDLE.
    always_comb begin
        state_nxt  = state;
        last_nxt   = last;
        gnt_nxt    = gnt;
        sel_nxt    = sel;
        valid_nxt  = bus_valid;
        hold_nxt   = hold_cnt;
        take_grant = 1'b0;

        pick = rr_pick(req, last);
        keep = req[sel] && ((HOLD_LIM == 8'd0) || (hold_cnt < HOLD_LIM));

        case (state)
            IDLE: begin
                if (pick[3]) take_grant = 1'b1;
            end
            GRANT: begin
                if (keep) begin
                    hold_nxt = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
                end else if (pick[3]) begin
                    take_grant = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 8'h00;
                    valid_nxt = 1'b0;
                    hold_nxt  = 8'h00;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 8'h00;
                valid_nxt = 1'b0;
                hold_nxt  = 8'h00;
            end
        endcase

        if (take_grant) begin
            state_nxt = GRANT;
            gnt_nxt   = 8'b1 << pick[2:0];
            sel_nxt   = pick[2:0];
            last_nxt  = pick[2:0];
            valid_nxt = 1'b1;
            hold_nxt  = 8'd1;
        end
    end

endmodule

// File: tb/tb_mux8_bus_arbiter.sv
// tb_mux8_bus_arbiter: instantiates two arbiters that share one req bus.
// One arbiter has MAX_HOLD=3 and the other is unlimited (MAX_HOLD=0).
// Both are compared every cycle against an integer-level reference model,
// and directed scenarios are also checked against constants.
module tb_mux8_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;

  logic [7:0] gnt_o  [2];
  logic [2:0] sel_o  [2];
  logic       valid_o[2];
  logic [7:0] hold_o [2];

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mux8_bus_arbiter #(.MAX_HOLD(3)) dut_lim (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_o[0]), .sel(sel_o[0]), .bus_valid(valid_o[0]), .hold_cnt(hold_o[0])
  );

  mux8_bus_arbiter #(.MAX_HOLD(0)) dut_unl (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_o[1]), .sel(sel_o[1]), .bus_valid(valid_o[1]), .hold_cnt(hold_o[1])
  );

  // ---------------- reference model ----------------
  // owner is -1 when idle; last is the round-robin pointer.
  int hold_lim[2] = '{3, 0};
  int m_owner[2]  = '{-1, -1};
  int m_cnt[2]    = '{0, 0};
  int m_last[2]   = '{7, 7};
  int m_sel[2]    = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_owner[d] = -1;
        m_cnt[d]   = 0;
        m_last[d]  = 7;
        m_sel[d]   = 0;
      end else if (m_owner[d] >= 0 && req[m_owner[d]] &&
                   (hold_lim[d] == 0 || m_cnt[d] < hold_lim[d])) begin
        m_cnt[d] = (m_cnt[d] >= 255) ? 255 : m_cnt[d] + 1;
      end else begin
        int w;
        w = -1;
        for (int k = 1; k <= 8; k++) begin
          if (w < 0 && req[(m_last[d] + k) % 8]) w = (m_last[d] + k) % 8;
        end
        if (w >= 0) begin
          m_owner[d] = w;
          m_last[d]  = w;
          m_sel[d]   = w;
          m_cnt[d]   = 1;
        end else begin
          m_owner[d] = -1;
          m_cnt[d]   = 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_models();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d gnt", d), 32'(gnt_o[d]),
            (m_owner[d] >= 0) ? (32'd1 << m_owner[d]) : 32'd0);
      check($sformatf("d%0d sel", d), 32'(sel_o[d]), 32'(m_sel[d]));
      check($sformatf("d%0d bus_valid", d), 32'(valid_o[d]), 32'(m_owner[d] >= 0));
      check($sformatf("d%0d hold_cnt", d), 32'(hold_o[d]), 32'(m_cnt[d]));
    end
  endtask

  // ---------------- driver ----------------
  // At each falling edge, check the outputs of the previous rising edge and
  // then drive the next request vector.
  task automatic step(input logic [7:0] r);
    @(negedge clk);
    check_models();
    req = r;
  endtask

  task automatic idle2();
    step(8'h00);
    step(8'h00);
  endtask

  int dur[8];
  logic [7:0] r_state;

  initial begin
    #1 rst_n = 1'b0;
    req = 8'hFF;

    // Reset held with every requester active: all outputs stay zero.
    step(8'hFF);
    step(8'hFF);
    for (int d = 0; d < 2; d++) begin
      check("rst gnt", 32'(gnt_o[d]), 32'h0);
      check("rst valid", 32'(valid_o[d]), 32'h0);
      check("rst sel", 32'(sel_o[d]), 32'h0);
    end
    rst_n = 1'b1;

    // First grant after reset goes to requester 0. With the limit at 3 the
    // grant then rotates 0,0,0,1,1,1,... and wraps from 7 back to 0.
    step(8'hFF);
    check("first gnt", 32'(gnt_o[0]), 32'h01);
    check("first hold", 32'(hold_o[0]), 32'd1);
    check("first valid", 32'(valid_o[0]), 32'd1);
    for (int t = 1; t < 27; t++) begin
      step(8'hFF);
      check("rr sel", 32'(sel_o[0]), 32'((t / 3) % 8));
      check("rr gnt", 32'(gnt_o[0]), 32'd1 << ((t / 3) % 8));
    end

    // Requester 5 holds req high for three cycles.
    idle2();
    step(8'h20);
    step(8'h20);
    check("r5 gnt c1", 32'(gnt_o[0]), 32'h20);
    step(8'h20);
    check("r5 gnt c2", 32'(gnt_o[1]), 32'h20);
    step(8'h00);
    check("r5 gnt c3", 32'(gnt_o[0]), 32'h20);
    step(8'h00);
    check("r5 idle gnt", 32'(gnt_o[0]), 32'h0);
    check("r5 idle valid", 32'(valid_o[1]), 32'h0);
    check("r5 idle sel", 32'(sel_o[0]), 32'd5);

    // Owner 2 drops req while 6 and 0 request: 6 takes over with no idle cycle.
    idle2();
    step(8'h04);
    step(8'h41);
    check("own2 gnt", 32'(gnt_o[0]), 32'h04);
    step(8'h41);
    check("handoff gnt", 32'(gnt_o[0]), 32'h40);
    check("handoff gnt unl", 32'(gnt_o[1]), 32'h40);
    check("handoff valid", 32'(valid_o[0]), 32'd1);

    // Only requester 3 for ten cycles: the grant stays, and hold_cnt counts 1,2,3 repeatedly.
    idle2();
    step(8'h08);
    for (int t = 0; t < 10; t++) begin
      step(8'h08);
      check("solo gnt", 32'(gnt_o[0]), 32'h08);
      check("solo hold", 32'(hold_o[0]), 32'((t % 3) + 1));
    end

    // Reset during a grant to owner 4, then release with req=0x30.
    idle2();
    step(8'h10);
    step(8'h10);
    step(8'h10);
    check("own4 gnt", 32'(gnt_o[0]), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("async gnt", 32'(gnt_o[d]), 32'h0);
      check("async valid", 32'(valid_o[d]), 32'h0);
      check("async hold", 32'(hold_o[d]), 32'h0);
      check("async sel", 32'(sel_o[d]), 32'h0);
    end
    req = 8'h30;
    step(8'h30);
    rst_n = 1'b1;
    step(8'h30);
    check("post rst gnt", 32'(gnt_o[0]), 32'h10);
    check("post rst gnt unl", 32'(gnt_o[1]), 32'h10);

    // Randomized requesters. Each holds req on or off for a random duration,
    // and one asynchronous reset is applied part-way through.
    for (int i = 0; i < 8; i++) dur[i] = 0;
    r_state = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (dur[i] == 0) begin
          r_state[i] = ($urandom_range(0, 2) != 0);
          dur[i] = $urandom_range(1, 12);
        end else begin
          dur[i]--;
        end
      end
      step(r_state);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #1 check_models();
        step(r_state);
        rst_n = 1'b1;
      end
    end

    // Long solo hold: the unlimited arbiter saturates hold_cnt at 255.
    idle2();
    for (int t = 0; t < 300; t++) step(8'h01);
    check("sat hold", 32'(hold_o[1]), 32'd255);
    check("sat gnt", 32'(gnt_o[1]), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
